// File: rtl/c6_pkg.sv
// Shared board, cell-code, weight-code and state definitions for the c6 engine.
package c6_pkg;

  localparam int brdHeight = 19;
  localparam int brdWidth  = 19;

  typedef enum logic [1:0] {
    Black = 2'd0,
    White = 2'd1,
    Empty = 2'd2
  } cell_t;

  typedef enum logic [3:0] {
    W1 = 4'd0,
    W2 = 4'd1,
    W3 = 4'd2,
    W4 = 4'd3,
    W5 = 4'd4,
    t1 = 4'd5,
    t2 = 4'd6,
    t3 = 4'd7,
    T  = 4'd8
  } weight_t;

  // weight_accum state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ACCUM  = 3'd2;
  localparam logic [2:0] ST_SEARCH = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/score_ram.sv
// Per-cell score/threat storage: combinational read, synchronous write, no reset.
module score_ram #(
  parameter int DEPTH  = 361,
  parameter int DATA_W = 9,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port; contents are initialised by the owner, not by reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_accum.sv
// Accumulates per-cell move weights and searches the board for the best cell.
module weight_accum #(
  parameter int         brdHeight = c6_pkg::brdHeight,
  parameter int         brdWidth  = c6_pkg::brdWidth,
  parameter int         SCORE_W   = 8,
  parameter logic [3:0] T_CODE    = 4'd8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               wrEna,
  input  logic [4:0]         wrX,
  input  logic [4:0]         wrY,
  input  logic [3:0]         wrWeight,
  input  logic               scanDone,
  output logic               busy,
  output logic               done,
  output logic               bestValid,
  output logic [4:0]         bestX,
  output logic [4:0]         bestY,
  output logic [SCORE_W-1:0] bestScore
);

  import c6_pkg::*;

  localparam int NCELL  = brdHeight * brdWidth;
  localparam int IDX_W  = $clog2(NCELL);
  localparam int DATA_W = SCORE_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELL - 1);
  localparam logic [4:0]       LAST_Y   = 5'(brdWidth - 1);

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [4:0]         scan_x, scan_y;
  logic               run_valid, run_flag;
  logic [SCORE_W-1:0] run_score;
  logic [4:0]         run_x, run_y;

  logic               wr_ok;
  logic [IDX_W-1:0]   wr_idx;
  logic               we;
  logic [IDX_W-1:0]   waddr, raddr;
  logic [DATA_W-1:0]  wdata, rdata;
  logic               rd_flag;
  logic [SCORE_W-1:0] rd_score, sat_score;
  logic [SCORE_W:0]   sum;
  logic               better;
  logic               nxt_valid;
  logic [SCORE_W-1:0] nxt_score;
  logic [4:0]         nxt_x, nxt_y;

  score_ram #(
    .DEPTH (NCELL),
    .DATA_W(DATA_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign busy     = (state != ST_IDLE);
  assign rd_flag  = rdata[SCORE_W];
  assign rd_score = rdata[SCORE_W-1:0];
  assign wr_ok    = wrEna && (state == ST_ACCUM) &&
                    (int'(wrX) < brdHeight) && (int'(wrY) < brdWidth);
  assign wr_idx   = IDX_W'(int'(wrX) * brdWidth + int'(wrY));
  assign sum      = {1'b0, rd_score} + DATA_W'(wrWeight);
  assign sat_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

  // Threat flag outranks score; strict compare keeps the earlier (lower) index on ties
  assign better = (rd_flag & ~run_flag) |
                  ((rd_flag == run_flag) & (rd_score > run_score));

  // Storage port steering: CLEAR zeroes by idx, ACCUM read-modify-writes, SEARCH reads by idx
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = '0;
    raddr = idx;
    case (state)
      ST_CLEAR: we = 1'b1;
      ST_ACCUM: begin
        raddr = wr_idx;
        waddr = wr_idx;
        if (wr_ok) begin
          we    = 1'b1;
          wdata = (wrWeight == T_CODE) ? {1'b1, rd_score} : {rd_flag, sat_score};
        end
      end
      default: ;
    endcase
  end

  // Running best including the cell currently being visited
  always_comb begin
    nxt_valid = run_valid;
    nxt_score = run_score;
    nxt_x     = run_x;
    nxt_y     = run_y;
    if (better) begin
      nxt_valid = 1'b1;
      nxt_score = rd_score;
      nxt_x     = scan_x;
      nxt_y     = scan_y;
    end
  end

  // Evaluation sequencer, search registers and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      scan_x    <= '0;
      scan_y    <= '0;
      run_valid <= 1'b0;
      run_flag  <= 1'b0;
      run_score <= '0;
      run_x     <= '0;
      run_y     <= '0;
      done      <= 1'b0;
      bestValid <= 1'b0;
      bestX     <= '0;
      bestY     <= '0;
      bestScore <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CLEAR;
            idx   <= '0;
          end
        end
        ST_CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= ST_ACCUM;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_ACCUM: begin
          if (scanDone) begin
            state     <= ST_SEARCH;
            idx       <= '0;
            scan_x    <= '0;
            scan_y    <= '0;
            run_valid <= 1'b0;
            run_flag  <= 1'b0;
            run_score <= '0;
            run_x     <= '0;
            run_y     <= '0;
          end
        end
        ST_SEARCH: begin
          if (better) begin
            run_valid <= 1'b1;
            run_flag  <= rd_flag;
            run_score <= rd_score;
            run_x     <= scan_x;
            run_y     <= scan_y;
          end
          if (scan_y == LAST_Y) begin
            scan_y <= '0;
            scan_x <= scan_x + 1'b1;
          end else begin
            scan_y <= scan_y + 1'b1;
          end
          if (idx == LAST_IDX) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            bestValid <= nxt_valid;
            bestX     <= nxt_x;
            bestY     <= nxt_y;
            bestScore <= nxt_score;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_accum.sv
// Directed self-checking bench for weight_accum.
module tb_weight_accum;

  logic       clk = 1'b0;
  logic       reset, start, wrEna, scanDone;
  logic [4:0] wrX, wrY;
  logic [3:0] wrWeight;
  logic       busy, done, bestValid;
  logic [4:0] bestX, bestY;
  logic [7:0] bestScore;

  int checks = 0;
  int errors = 0;

  weight_accum #(
    .brdHeight(19),
    .brdWidth (19),
    .SCORE_W  (8),
    .T_CODE   (4'd8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wrEna    (wrEna),
    .wrX      (wrX),
    .wrY      (wrY),
    .wrWeight (wrWeight),
    .scanDone (scanDone),
    .busy     (busy),
    .done     (done),
    .bestValid(bestValid),
    .bestX    (bestX),
    .bestY    (bestY),
    .bestScore(bestScore)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start an evaluation and ride through the 361-cycle CLEAR into ACCUM
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (361) tick;
    check("busy_in_accum", busy, 1);
  endtask

  task automatic wr(input logic [4:0] x, input logic [4:0] y, input logic [3:0] w);
    wrX      = x;
    wrY      = y;
    wrWeight = w;
    wrEna    = 1'b1;
    tick;
    wrEna    = 1'b0;
  endtask

  // Pulse scanDone (any wrEna already set up rides the same edge), then wait for done.
  // done is expected high while the 362nd edge after the scanDone edge samples it,
  // i.e. first seen just after edge 361.
  task automatic finish(input string tag, input logic ev, input logic [4:0] ex,
                        input logic [4:0] ey, input logic [7:0] es);
    int lat;
    scanDone = 1'b1;
    tick;
    scanDone = 1'b0;
    wrEna    = 1'b0;
    lat = 0;
    for (int n = 1; n <= 400; n++) begin
      tick;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, lat, 361);
    check({tag, "_valid"}, bestValid, ev);
    check({tag, "_x"}, bestX, ex);
    check({tag, "_y"}, bestY, ey);
    check({tag, "_score"}, bestScore, es);
    tick;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; wrEna = 1'b0; scanDone = 1'b0;
    wrX = '0; wrY = '0; wrWeight = '0;
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bestValid, 0);
    check("rst_x", bestX, 0);
    check("rst_y", bestY, 0);
    check("rst_score", bestScore, 0);
    reset = 1'b0;
    tick;

    // Accumulation with back-to-back writes to one cell
    do_start;
    wr(5'd3, 5'd4, 4'd2);
    wr(5'd3, 5'd4, 4'd3);
    wr(5'd10, 5'd10, 4'd4);
    finish("basic", 1'b1, 5'd3, 5'd4, 8'd5);

    // Results hold in IDLE; scanDone/wrEna there change nothing
    scanDone = 1'b1; wrX = 5'd0; wrY = 5'd0; wrWeight = 4'd4; wrEna = 1'b1;
    tick;
    scanDone = 1'b0; wrEna = 1'b0;
    repeat (4) tick;
    check("idle_busy", busy, 0);
    check("hold_x", bestX, 3);
    check("hold_y", bestY, 4);
    check("hold_score", bestScore, 5);

    // Threat flag beats a higher score
    do_start;
    wr(5'd18, 5'd18, 4'd8);
    wr(5'd0, 5'd0, 4'd4);
    finish("threat", 1'b1, 5'd18, 5'd18, 8'd0);

    // Saturation at 255
    do_start;
    for (int i = 0; i < 70; i++) wr(5'd5, 5'd5, 4'd4);
    finish("saturate", 1'b1, 5'd5, 5'd5, 8'd255);

    // Equal scores: lower index (1,2)=21 wins over (2,1)=39
    do_start;
    wr(5'd2, 5'd1, 4'd3);
    wr(5'd1, 5'd2, 4'd3);
    finish("tie", 1'b1, 5'd1, 5'd2, 8'd3);

    // No writes at all
    do_start;
    finish("empty", 1'b0, 5'd0, 5'd0, 8'd0);

    // Out-of-range writes are dropped ((0,31) would alias cell 31 if not checked)
    do_start;
    wr(5'd19, 5'd0, 4'd4);
    wr(5'd0, 5'd31, 4'd4);
    finish("range", 1'b0, 5'd0, 5'd0, 8'd0);

    // Write on the same cycle as scanDone is applied before the search
    do_start;
    wrX = 5'd7; wrY = 5'd7; wrWeight = 4'd1; wrEna = 1'b1;
    finish("same_cycle", 1'b1, 5'd7, 5'd7, 8'd1);

    // Reset mid-SEARCH aborts; a new run clears the stale score at (9,9)
    do_start;
    wr(5'd9, 5'd9, 4'd4);
    scanDone = 1'b1;
    tick;
    scanDone = 1'b0;
    repeat (100) tick;
    check("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", bestValid, 0);
    check("abort_x", bestX, 0);
    tick;
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 400; n++) begin
      tick;
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_idle", busy, 0);
    do_start;
    finish("after_abort", 1'b0, 5'd0, 5'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_accum.md
WEIGHT_ACCUM -- requirements
Module: weight_accum

Interface
REQ-001 Parameter brdHeight, default 19: board rows, x range 0..brdHeight-1.
REQ-002 Parameter brdWidth, default 19: board columns, y range 0..brdWidth-1.
REQ-003 Parameter SCORE_W, default 8: width of the per-cell score accumulator.
REQ-004 Parameter T_CODE, default 4'd8: weight code marking a threat or winning cell.
REQ-005 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a new move evaluation.
REQ-008 wrEna  input  1  weight-write strobe from the scan stages.
REQ-009 wrX  input  5  row of the cell being weighted.
REQ-010 wrY  input  5  column of the cell being weighted.
REQ-011 wrWeight  input  4  weight code to add.
REQ-012 scanDone  input  1  one-cycle pulse; all scan stages have finished.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse; result outputs are valid.
REQ-015 bestValid  output  1  at least one cell has a non-zero score or a set threat flag.
REQ-016 bestX  output  5  row of the selected cell.
REQ-017 bestY  output  5  column of the selected cell.
REQ-018 bestScore  output  SCORE_W  accumulated score of the selected cell.

Function
REQ-019 The block SHALL hold one score (SCORE_W bits) and one threat flag per cell, brdHeight*brdWidth cells, with index = x*brdWidth + y.
REQ-020 The state machine SHALL have states IDLE, CLEAR, ACCUM, SEARCH and DONE.
REQ-021 IDLE SHALL go to CLEAR when start=1; start SHALL be ignored in every other state.
REQ-022 CLEAR SHALL zero one cell per cycle, index 0 to 360, then go to ACCUM; it takes 361 cycles.
REQ-023 In ACCUM, wrEna=1 with wrX<brdHeight and wrY<brdWidth SHALL update the cell in the same edge:
  - when wrWeight==T_CODE: set the threat flag; leave the score unchanged.
  - otherwise: score = score + wrWeight, saturating at 2^SCORE_W-1.
REQ-024 A write with wrX or wrY out of range SHALL be dropped with no side effects.
REQ-025 wrEna outside ACCUM SHALL be ignored.
REQ-026 Back-to-back writes to the same cell on consecutive cycles SHALL both accumulate; no write is lost.
REQ-027 scanDone in ACCUM SHALL move to SEARCH; if wrEna is high on the same cycle, that write SHALL be applied first.
REQ-028 scanDone outside ACCUM SHALL be ignored.
REQ-029 SEARCH SHALL visit one cell per cycle in index order, 0 to 360, keeping a running best.
REQ-030 The running best SHALL rank cells by threat flag first, then by score; on a tie the lower index is kept.
REQ-031 After the last cell, the block SHALL enter DONE, which lasts one cycle:
  - done=1 and the best* outputs are loaded.
  - the next state is IDLE.
REQ-032 done SHALL be high exactly 362 rising edges after the edge that sampled scanDone.
REQ-033 If no cell has a non-zero score or a set flag, bestValid=0, bestX=0, bestY=0 and bestScore=0.
REQ-034 bestValid, bestX, bestY and bestScore SHALL hold their value until the next DONE or reset.

Reset
REQ-035 On reset: state=IDLE; busy, done, bestValid, bestX, bestY and bestScore all 0; the search registers cleared.
REQ-036 Score and flag storage need not be reset, because CLEAR initialises it.
REQ-037 Reset asserted mid-CLEAR, mid-ACCUM or mid-SEARCH SHALL abort the evaluation; done SHALL not pulse afterwards.

Structure
REQ-038 The shared package c6_pkg SHALL hold:
  - brdHeight and brdWidth.
  - the cell codes Black=0, White=1, Empty=2.
  - the weight codes W1..W5=0..4, t1..t3=5..7, T=8.
  - the state encodings of this block.
REQ-039 The score and flag storage SHALL be a sub-module score_ram: 361 x (SCORE_W+1) registers, one combinational read port and one synchronous write port, shared by CLEAR, ACCUM and SEARCH.

Verification
REQ-040 Scenario: start, then writes (3,4,w=2), (3,4,w=3), (10,10,w=4), then scanDone -> done after 362 cycles; bestX=3, bestY=4, bestScore=5, bestValid=1.
REQ-041 Scenario: write (18,18,T=8) and (0,0,w=4) -> best is 18,18 (flag beats score), bestScore=0.
REQ-042 Scenario: 70 writes of w=4 to (5,5) -> bestScore=255 (saturated); tie (1,2,w=3) and (2,1,w=3) -> best is 1,2 (lower index).
REQ-043 Scenario: no writes -> bestValid=0, best* outputs all 0; a write to (19,0) or (0,31) -> ignored, bestValid=0.
REQ-044 Scenario: reset during SEARCH -> busy=0 next cycle and no done pulse; a new start then clears the scores left by the earlier run.
REQ-045 Scenario: wrEna and scanDone on the same cycle, writing (7,7,w=1) as the only write -> best is 7,7 with bestScore=1.
